// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART RX packet parser.
// Frame checksum support is selected with the UART_PKT_CSUM_EN macro.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAY,
    CSUM,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_byte_fetch.sv
// Pops the RX FIFO one byte at a time and holds it in a single byte register,
// offered to the parser with a valid/ready handshake.
module uart_rx_byte_fetch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_empty,
  output logic       rx_rd_en,
  input  logic [7:0] rx_rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic       byte_land
);

  logic pend;

  // Pop only when the register will be free by the time the data lands.
  assign rx_rd_en  = !rx_empty && !pend && (!byte_valid || byte_ready);
  assign byte_land = pend;

  // NOTE: sequential state uses non-blocking assignments; the data register is
  // reset as well so the payload bus reads zero coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
    end else begin
      pend <= rx_rd_en;
      if (pend) begin
        byte_valid <= 1'b1;
        byte_data  <= rx_rd_data;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Frame parser on the UART RX FIFO: [SOF, LEN, PAYLOAD x LEN, (CSUM)] -> payload stream.
// Define UART_PKT_CSUM_EN to require the trailing checksum byte.
module uart_rx_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_empty,
  output logic             rx_rd_en,
  input  logic [7:0]       rx_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  logic             byte_valid, byte_ready, byte_land;
  logic [7:0]       byte_data;
  state_t           state, state_nxt;
  logic [7:0]       len_q, idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_run, tmo_hit, err_fire, len_load, pay_hs, is_last;
`ifdef UART_PKT_CSUM_EN
  logic [7:0]       csum_q;
`endif

  uart_rx_byte_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_empty   (rx_empty),
    .rx_rd_en   (rx_rd_en),
    .rx_rd_data (rx_rd_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .byte_land  (byte_land)
  );

  // The timer only runs while a frame is open and nothing is fetched or in flight.
  assign tmo_run = (state == LEN || state == PAY || state == CSUM) && !byte_valid && !byte_land;
  assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);
  assign is_last = (idx_q == len_q - 8'd1);
  assign m_data  = byte_data;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    pkt_done   = 1'b0;
    pkt_ok     = 1'b0;
    err_fire   = 1'b0;
    err_code   = ERR_NONE;
    len_load   = 1'b0;
    pay_hs     = 1'b0;
    case (state)
      HUNT: begin
        byte_ready = byte_valid;
        if (byte_valid && byte_data == SOF_BYTE) state_nxt = LEN;
      end
      LEN: begin
        byte_ready = byte_valid;
        if (byte_valid) begin
          if (byte_data != 8'd0 && byte_data <= MAX_LEN_B) begin
            len_load  = 1'b1;
            state_nxt = PAY;
          end else begin
            err_fire = 1'b1;
            err_code = ERR_LEN;
          end
        end else if (tmo_hit) begin
          err_fire = 1'b1;
          err_code = ERR_TMO;
        end
      end
      PAY: begin
        m_valid    = byte_valid;
        m_last     = byte_valid && is_last;
        byte_ready = byte_valid && m_ready;
        if (byte_valid && m_ready) begin
          pay_hs = 1'b1;
`ifdef UART_PKT_CSUM_EN
          if (is_last) state_nxt = CSUM;
`else
          if (is_last) state_nxt = DONE;
`endif
        end else if (tmo_hit) begin
          err_fire = 1'b1;
          err_code = ERR_TMO;
        end
      end
`ifdef UART_PKT_CSUM_EN
      CSUM: begin
        byte_ready = byte_valid;
        if (byte_valid) begin
          if (byte_data == csum_q) begin
            state_nxt = DONE;
          end else begin
            err_fire = 1'b1;
            err_code = ERR_CSUM;
          end
        end else if (tmo_hit) begin
          err_fire = 1'b1;
          err_code = ERR_TMO;
        end
      end
`endif
      DONE: begin
        pkt_done  = 1'b1;
        pkt_ok    = 1'b1;
        state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
    if (err_fire) begin
      pkt_done  = 1'b1;
      state_nxt = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      tmo_q   <= '0;
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (len_load) begin
        len_q <= byte_data;
        idx_q <= 8'd0;
      end else if (pay_hs) begin
        idx_q <= idx_q + 8'd1;
      end
      tmo_q <= (tmo_run && !tmo_hit) ? tmo_q + TMO_W'(1) : '0;
      if (state == DONE && pkt_cnt != {CNT_W{1'b1}}) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (err_fire && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef UART_PKT_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (len_load) begin
      csum_q <= byte_data;
    end else if (pay_hs) begin
      csum_q <= csum_q ^ byte_data;
    end
  end
`endif

endmodule
